// File: rtl/food_spawner.sv
// Food placement for the snake game: samples the random point stream on a
// spawn request, snaps it to the cell grid, rejects off-field cells, asks the
// body tracker whether the cell is occupied and commits the first free one.
module food_spawner #(
  parameter int CELL_SHIFT = 4,
  parameter int X_LIMIT    = 624,
  parameter int Y_LIMIT    = 464,
  parameter int MAX_TRIES  = 16
) (
  input  logic       VGA_clk,
  input  logic       rst,
  input  logic [9:0] randX,
  input  logic [8:0] randY,
  input  logic       spawn_req,
  output logic       occ_req,
  output logic [9:0] occ_x,
  output logic [8:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [9:0] food_x,
  output logic [8:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       spawn_fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CHECK,
    S_QUERY,
    S_COMMIT
  } state_t;

  // Grid snapping masks and limits sized to the coordinate widths
  localparam logic [9:0] X_MASK  = ~((10'd1 << CELL_SHIFT) - 10'd1);
  localparam logic [8:0] Y_MASK  = ~((9'd1 << CELL_SHIFT) - 9'd1);
  localparam logic [9:0] X_LIM   = 10'(X_LIMIT);
  localparam logic [8:0] Y_LIM   = 9'(Y_LIMIT);
  localparam logic [7:0] TRY_MAX = 8'(MAX_TRIES);

  state_t     state_q, state_d;
  logic [7:0] tries_q, tries_d;
  logic [9:0] cand_x_q, cand_x_d;
  logic [8:0] cand_y_q, cand_y_d;
  logic       occ_req_q, occ_req_d;
  logic [9:0] occ_x_q, occ_x_d;
  logic [8:0] occ_y_q, occ_y_d;
  logic [9:0] food_x_q, food_x_d;
  logic [8:0] food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;
  logic       spawn_fail_q, spawn_fail_d;
  logic       reject;

  // Next-state and output register computation; a reject from CHECK or QUERY
  // either retries with a fresh sample or gives up once the budget is spent
  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    occ_req_d    = occ_req_q;
    occ_x_d      = occ_x_q;
    occ_y_d      = occ_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    spawn_fail_d = 1'b0;
    reject       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (spawn_req) begin
          food_valid_d = 1'b0;
          tries_d      = 8'd0;
          state_d      = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        cand_x_d = randX & X_MASK;
        cand_y_d = randY & Y_MASK;
        tries_d  = tries_q + 8'd1;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if ((cand_x_q <= X_LIM) && (cand_y_q <= Y_LIM)) begin
          occ_req_d = 1'b1;
          occ_x_d   = cand_x_q;
          occ_y_d   = cand_y_q;
          state_d   = S_QUERY;
        end else begin
          reject = 1'b1;
        end
      end
      S_QUERY: begin
        if (occ_ack) begin
          occ_req_d = 1'b0;
          if (occ_hit) begin
            reject = 1'b1;
          end else begin
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        food_x_d     = cand_x_q;
        food_y_d     = cand_y_q;
        food_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reject) begin
      occ_req_d = 1'b0;
      if (tries_q < TRY_MAX) begin
        state_d = S_SAMPLE;
      end else begin
        spawn_fail_d = 1'b1;
        food_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    end
  end

  // State and output registers; reset clears everything, including a live query
  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tries_q      <= 8'd0;
      cand_x_q     <= 10'd0;
      cand_y_q     <= 9'd0;
      occ_req_q    <= 1'b0;
      occ_x_q      <= 10'd0;
      occ_y_q      <= 9'd0;
      food_x_q     <= 10'd0;
      food_y_q     <= 9'd0;
      food_valid_q <= 1'b0;
      spawn_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      occ_req_q    <= occ_req_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      spawn_fail_q <= spawn_fail_d;
    end
  end

  assign occ_req    = occ_req_q;
  assign occ_x      = occ_x_q;
  assign occ_y      = occ_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign spawn_fail = spawn_fail_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: directed vector table, hand-written corner
// sequences and randomized spawns against a transaction-level model.
module tb_food_spawner;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] randX;
  logic [8:0] randY;
  logic       spawn_req;
  logic       occ_req;
  logic [9:0] occ_x;
  logic [8:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic [9:0] food_x;
  logic [8:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       spawn_fail;

  always #5 clk = ~clk;

  food_spawner dut (
    .VGA_clk(clk), .rst(rst), .randX(randX), .randY(randY), .spawn_req(spawn_req),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .busy(busy),
    .spawn_fail(spawn_fail)
  );

  localparam int NC = 20000;
  localparam int NQ = 4096;

  // Random stream per clock edge and responder behaviour per query index
  int rvx [NC];
  int rvy [NC];
  int hit_tab [NQ];
  int dly_tab [NQ];

  int cyc, qidx, nchk, nerr, last_n;
  int wait_cnt, cur_dly;
  logic cur_hit;

  assign occ_ack = occ_req && (wait_cnt >= cur_dly);
  assign occ_hit = cur_hit;

  // Observed transaction
  int ob_n, ob_x [64], ob_y [64], ob_e [64];
  int fail_cnt, fail_edge;
  // Expected transaction
  int ex_n, ex_x [64], ex_y [64], ex_e [64];
  int ex_commit, ex_fx, ex_fy, ex_done;

  typedef struct {
    int rx;
    int ry;
    int qx;
    int qy;
    int qofs;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: note handshake before the edge, observe after it, drive next inputs
  task automatic tick();
    logic pre_req, pre_hs;
    int pre_x, pre_y;
    #1;
    pre_req = occ_req;
    pre_hs  = occ_req && occ_ack;
    pre_x   = int'(occ_x);
    pre_y   = int'(occ_y);
    @(posedge clk);
    #1;
    cyc++;
    if (pre_hs) begin
      if (ob_n < 64) begin
        ob_x[ob_n] = pre_x;
        ob_y[ob_n] = pre_y;
        ob_e[ob_n] = cyc;
      end
      ob_n++;
      qidx++;
      wait_cnt = 0;
    end else if (pre_req) begin
      wait_cnt++;
      chk("occ_hold_req", int'(occ_req), 1);
      chk("occ_hold_x", int'(occ_x), pre_x);
      chk("occ_hold_y", int'(occ_y), pre_y);
    end else begin
      wait_cnt = 0;
    end
    if (spawn_fail) begin
      fail_cnt++;
      fail_edge = cyc;
    end
    cur_dly = dly_tab[qidx];
    cur_hit = (hit_tab[qidx] != 0);
    randX   = 10'(rvx[cyc + 1]);
    randY   = 9'(rvy[cyc + 1]);
  endtask

  // Transaction-level prediction: samples happen on known edges, an off-field
  // candidate costs two cycles, a query resolves on the ack edge
  task automatic predict(input int n, input int q0);
    int t, tries, qi, a, rej, cx, cy;
    bit done;
    ex_n = 0; ex_commit = 0; ex_fx = 0; ex_fy = 0; ex_done = 0;
    t = n + 1; tries = 0; qi = q0; done = 0;
    while (!done) begin
      tries++;
      cx  = (rvx[t] / 16) * 16;
      cy  = (rvy[t] / 16) * 16;
      rej = 0;
      if (cx > 624 || cy > 464) begin
        rej = t + 1;
      end else begin
        a = t + 2 + dly_tab[qi];
        ex_x[ex_n] = cx; ex_y[ex_n] = cy; ex_e[ex_n] = a;
        ex_n++;
        if (hit_tab[qi] != 0) begin
          rej = a;
        end else begin
          ex_commit = 1; ex_fx = cx; ex_fy = cy; ex_done = a + 1;
          done = 1;
        end
        qi++;
      end
      if (!done) begin
        if (tries < 16) t = rej + 1;
        else begin
          ex_done = rej;
          done = 1;
        end
      end
    end
  endtask

  task automatic make_safe(input int from, input int len);
    for (int i = from; i < from + len && i < NC; i++)
      if (rvy[i] >= 480) rvy[i] = $urandom_range(0, 479);
  endtask

  task automatic run_spawn(input bit noise, input string tag);
    int n, guard, m;
    n = cyc + 1;
    last_n = n;
    predict(n, qidx);
    ob_n = 0; fail_cnt = 0; fail_edge = -1;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    chk("busy_start", int'(busy), 1);
    guard = 0;
    while (busy && guard < 400) begin
      if (noise && $urandom_range(0, 2) == 0) spawn_req = 1'b1;
      tick();
      spawn_req = 1'b0;
      guard++;
    end
    if (busy) begin
      chk("timeout_busy", int'(busy), 0);
      return;
    end
    chk("done_edge", cyc - n, ex_done - n);
    chk("num_queries", ob_n, ex_n);
    m = (ob_n < ex_n) ? ob_n : ex_n;
    if (m > 64) m = 64;
    for (int i = 0; i < m; i++) begin
      chk("query_x", ob_x[i], ex_x[i]);
      chk("query_y", ob_y[i], ex_y[i]);
      chk("query_edge", ob_e[i] - n, ex_e[i] - n);
    end
    chk("food_valid", int'(food_valid), ex_commit);
    chk("fail_pulses", fail_cnt, ex_commit ? 0 : 1);
    if (ex_commit != 0) begin
      chk("food_x", int'(food_x), ex_fx);
      chk("food_y", int'(food_y), ex_fy);
    end else begin
      chk("fail_edge", fail_edge - n, ex_done - n);
    end
    tick();
    chk("idle_after", int'(busy), 0);
    chk("fail_one_cycle", int'(spawn_fail), 0);
    $display("spawn %s: N=%0d queries=%0d valid=%0d food=(%0d,%0d) fail=%0d",
             tag, n, ob_n, food_valid, food_x, food_y, fail_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_occ_req"}, int'(occ_req), 0);
    chk({tag, "_occ_x"}, int'(occ_x), 0);
    chk({tag, "_occ_y"}, int'(occ_y), 0);
    chk({tag, "_food_x"}, int'(food_x), 0);
    chk({tag, "_food_y"}, int'(food_y), 0);
    chk({tag, "_food_valid"}, int'(food_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_spawn_fail"}, int'(spawn_fail), 0);
  endtask

  initial begin
    int n, guard;
    nchk = 0; nerr = 0; cyc = 0; qidx = 0; wait_cnt = 0;
    for (int i = 0; i < NC; i++) begin
      rvx[i] = $urandom_range(0, 610);
      rvy[i] = ($urandom_range(0, 3) == 0) ? 480 : $urandom_range(0, 480);
    end
    for (int i = 0; i < NQ; i++) begin
      hit_tab[i] = ($urandom_range(0, 9) < 3) ? 1 : 0;
      dly_tab[i] = $urandom_range(0, 3);
    end
    vt[0] = '{100, 37, 96, 32, 3};
    vt[1] = '{610, 480, 192, 192, 5};
    vt[2] = '{610, 470, 608, 464, 3};
    vt[3] = '{0, 0, 0, 0, 3};
    vt[4] = '{15, 15, 0, 0, 3};
    vt[5] = '{16, 463, 16, 448, 3};
    vt[6] = '{609, 479, 608, 464, 3};
    vt[7] = '{0, 480, 192, 192, 5};
    vt[8] = '{305, 240, 304, 240, 3};

    rst = 1'b1; spawn_req = 1'b0;
    cur_dly = dly_tab[0]; cur_hit = (hit_tab[0] != 0);
    randX = 10'(rvx[1]); randY = 9'(rvy[1]);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Directed vectors: single-candidate spawns, zero-wait free responder
    for (int v = 0; v < 9; v++) begin
      n = cyc + 1;
      rvx[n + 1] = vt[v].rx; rvy[n + 1] = vt[v].ry;
      rvx[n + 3] = 200;      rvy[n + 3] = 200;
      hit_tab[qidx] = 0; dly_tab[qidx] = 0;
      cur_dly = 0; cur_hit = 1'b0;
      run_spawn(1'b0, "vector");
      chk("tbl_queries", ob_n, 1);
      chk("tbl_qx", (ob_n > 0) ? ob_x[0] : -1, vt[v].qx);
      chk("tbl_qy", (ob_n > 0) ? ob_y[0] : -1, vt[v].qy);
      chk("tbl_qedge", (ob_n > 0) ? ob_e[0] - n : -1, vt[v].qofs);
      chk("tbl_food_x", int'(food_x), vt[v].qx);
      chk("tbl_food_y", int'(food_y), vt[v].qy);
    end

    // Three occupied cells then a free one
    make_safe(cyc, 200);
    for (int i = 0; i < 4; i++) begin
      hit_tab[qidx + i] = (i < 3) ? 1 : 0;
      dly_tab[qidx + i] = 0;
    end
    cur_dly = 0; cur_hit = 1'b1;
    run_spawn(1'b0, "hit3");
    chk("hit3_queries", ob_n, 4);
    chk("hit3_fail", fail_cnt, 0);
    chk("hit3_valid", int'(food_valid), 1);

    // Every cell occupied: budget exhausted
    make_safe(cyc, 400);
    for (int i = 0; i < 16; i++) begin
      hit_tab[qidx + i] = 1;
      dly_tab[qidx + i] = 0;
    end
    cur_dly = 0; cur_hit = 1'b1;
    run_spawn(1'b0, "allhit");
    chk("allhit_queries", ob_n, 16);
    chk("allhit_fail", fail_cnt, 1);
    chk("allhit_valid", int'(food_valid), 0);
    chk("allhit_busy", int'(busy), 0);

    // Slow responder with spawn_req noise during the wait
    make_safe(cyc, 200);
    hit_tab[qidx] = 0; dly_tab[qidx] = 5;
    cur_dly = 5; cur_hit = 1'b0;
    run_spawn(1'b1, "slow");
    chk("slow_queries", ob_n, 1);
    chk("slow_qedge", (ob_n > 0) ? ob_e[0] - last_n : -1, 8);

    // Reset while a query is outstanding
    make_safe(cyc, 200);
    hit_tab[qidx] = 0; dly_tab[qidx] = 20;
    cur_dly = 20; cur_hit = 1'b0;
    ob_n = 0;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    guard = 0;
    while (!occ_req && guard < 10) begin
      tick();
      guard++;
    end
    chk("rstq_reached_query", int'(occ_req), 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_query");
    qidx++;
    wait_cnt = 0;
    cur_dly = dly_tab[qidx]; cur_hit = (hit_tab[qidx] != 0);
    #2 rst = 1'b0;
    hit_tab[qidx] = 0;
    cur_hit = 1'b0;
    run_spawn(1'b0, "after_rst_query");
    chk("rstq_restart_valid", int'(food_valid), 1);

    // Reset while food is placed
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_food");
    #2 rst = 1'b0;
    run_spawn(1'b0, "after_rst_food");

    // Randomized spawns against the model
    for (int k = 0; k < 60; k++) begin
      run_spawn(k[0], "random");
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
